rob_status_mw: RTL and testbench
================================

// Module: rob_status_mw
// PURPOSE
//  Multi-way reorder-buffer status tracker; next generation of the single-issue ROB status block.
//  Allocates up to DEC_W entries per cycle at dispatch and accepts WB_PORTS parallel writebacks.
//  Retires up to COM_W consecutive completed entries per cycle, in order, from the head.
//  Sits between decode/rename, the execution writeback ports and the architectural commit stage.
//  Raises flush_ on the first retiring entry with an exception, branch mispredict or jump miss.
// PARAMETERS
//  ADDR       `AddrWidth  PC width
//  ROB_DEPTH  `RobDepth   entries; power of 2, >= 2*max(DEC_W,COM_W)
//  DEC_W      2           dispatch slots per cycle
//  WB_PORTS   3           writeback ports
//  COM_W      2           commit slots per cycle
//  ROB        $clog2(ROB_DEPTH)  derived index width
// PORTS
//  clk           in   1             clock
//  reset         in   1             synchronous, active-high reset
//  dec_e_        in   DEC_W         per-slot dispatch enable, active-low; enabled slots contiguous from slot 0
//  dec_pc        in   DEC_W*ADDR    PC per slot
//  dec_rd        in   DEC_W*RegFile_t  destination register per slot
//  dec_invalid   in   DEC_W         slot needs no writeback; entry allocated already complete
//  dec_rob_id    out  DEC_W*ROB     entry ids assigned to this cycle's slots (tail+k)
//  dec_ready     out  1             free entries >= DEC_W
//  wb_e_         in   WB_PORTS      writeback enable, active-low
//  wb_rob_id     in   WB_PORTS*ROB  target entry
//  wb_exp_       in   WB_PORTS      exception, active-low
//  wb_exp_code   in   WB_PORTS*ExpCode_t  exception code
//  wb_pred_miss_ in   WB_PORTS      branch mispredict, active-low
//  wb_jump_miss_ in   WB_PORTS      jump target miss, active-low
//  commit_e_     out  COM_W         per-slot commit, active-low; asserted slots contiguous from 0
//  com_rob_id    out  COM_W*ROB     retiring ids (head+k)
//  com_pc/com_rd out  COM_W*(ADDR/RegFile_t)  retiring PC and destination
//  com_exp_      out  COM_W         exception flag; com_exp_code out COM_W*ExpCode_t
//  flush_        out  1             pipeline flush, active-low
//  rob_busy      out  1             ROB full
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all entries invalid and not ready; commit_e_ all 1, flush_=1,
//    rob_busy=0, dec_ready=1, dec_rob_id={0..DEC_W-1}; com_* driven 0.
//  - Dispatch is accepted only when dec_ready=1; otherwise the whole group is dropped.
//    Accepted entries become valid next cycle. dec_invalid entries are ready next cycle with status cleared.
//  - Writeback marks its entry ready and stores status; effect visible next cycle (wb->commit >= 1 cycle).
//    Writeback to an invalid entry is ignored. Same id on two ports: lowest port wins (sim assertion).
//  - Commit is combinational from registered state: slot k retires iff entries head..head+k are all valid
//    and ready, and no slot j<k is faulting. A faulting entry (exp_, br_miss_ or jump_miss_ low) retires,
//    asserts flush_ the same cycle, and blocks all later slots.
//  - Flush: next cycle all entries invalid/not ready, head=tail=0, count=0; dispatch in the flush cycle is dropped.
//  - Counters: count += accepted - retired; head/tail wrap modulo ROB_DEPTH.
//    Entries freed this cycle are not reallocatable until the next cycle.
//    rob_busy = (count==ROB_DEPTH); dec_ready = (ROB_DEPTH-count >= DEC_W).
//  - The reset branch takes priority over the flush branch; reset mid-flush leaves the reset state.
// CONFIGURATION
//  ROB_PERF_EN defined: adds out ports perf_commit_cnt[31:0] (sum of retired slots) and
//    perf_flush_cnt[31:0]; both saturating, cleared by reset, not cleared by flush.
//  ROB_PERF_EN undefined: ports and counters absent; the remaining behaviour is identical.
// STRUCTURE
//  rob.svh: RobInfo_t {pc, rd, br_inst_, br_pred_taken_, jump_inst_}, RobStat_t {br_miss_, jump_miss_,
//    exp_, exp_code}; both shared with downstream commit logic.
//  Sub-module rob_commit_sel: combinational head-window ready/fault scan producing commit_e_ and flush_.
//  Info storage: multi-port regfile (DEC_W write, COM_W read); status storage: WB_PORTS write, COM_W read.
// TESTING
//  1 Reset; dispatch 2/cyc x4 (DEPTH=8) -> dec_rob_id 0,1..6,7; rob_busy=1; dec_ready=0; group 5 dropped.
//  2 WB ids 1 then 0 (next cyc) -> no commit until both ready; then commit_e_=2'b00, com_rob_id={1,0}.
//  3 WB id 0 with wb_pred_miss_=0, id 1 clean -> slot0 commits, flush_=0, slot1 not committed; next cyc count=0.
//  4 Full ROB: commit 2 + dispatch 2 same cycle -> dispatch dropped; next cycle dispatch gets ids at wrapped tail.
//  5 Three WB ports same cycle to ids 3,4,5 -> all three commit over two cycles (2 then 1) in order.
//  6 ROB_PERF_EN: scenarios 2+3 -> perf_commit_cnt=3, perf_flush_cnt=1; reset -> both 0.

Source files
------------

// File: rtl/rob_status_mw_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : rob_status_mw_pkg                                              |
// | Description : Shared ROB entry types (info/status) and default sizing.       |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
package rob_status_mw_pkg;

  localparam int c_ADDR_WIDTH = 32;
  localparam int c_ROB_DEPTH  = 8;

  localparam int c_REG_W = 5;
  localparam int c_EXP_W = 4;

  typedef logic [c_REG_W-1:0] RegFile_t;
  typedef logic [c_EXP_W-1:0] ExpCode_t;

  typedef struct packed {
    logic [c_ADDR_WIDTH-1:0] pc;
    RegFile_t                rd;
    logic                    br_inst_;
    logic                    br_pred_taken_;
    logic                    jump_inst_;
  } RobInfo_t;

  typedef struct packed {
    logic     br_miss_;
    logic     jump_miss_;
    logic     exp_;
    ExpCode_t exp_code;
  } RobStat_t;

  localparam RobStat_t c_STAT_CLEAN = '{br_miss_: 1'b1, jump_miss_: 1'b1, exp_: 1'b1, exp_code: '0};

  // Any of the three active-low fault flags asserted means the entry redirects the pipeline.
  function automatic logic stat_fault(input RobStat_t s);
    return ~(s.br_miss_ & s.jump_miss_ & s.exp_);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_commit_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : rob_commit_sel                                                 |
// | Description : In-order head-window scan producing commit slots and flush.    |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module rob_commit_sel #(
  parameter int COM_W = 2
) (
  input  logic [COM_W-1:0] i_win_done,
  input  logic [COM_W-1:0] i_win_fault,
  output logic [COM_W-1:0] o_commit_e_,
  output logic             o_flush_
);

  logic w_blocked;

  // A faulting entry still retires but stops every younger slot behind it.
  always_comb begin
    o_commit_e_ = '1;
    o_flush_    = 1'b1;
    w_blocked   = 1'b0;
    for (int k = 0; k < COM_W; k++) begin
      if (!w_blocked && i_win_done[k]) begin
        o_commit_e_[k] = 1'b0;
        if (i_win_fault[k]) begin
          o_flush_  = 1'b0;
          w_blocked = 1'b1;
        end
      end else begin
        w_blocked = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_status_mw.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : rob_status_mw                                                  |
// | Description : Multi-way ROB status tracker: DEC_W dispatch, WB_PORTS         |
// |               writeback, COM_W in-order commit with flush on fault.          |
// |               Define ROB_PERF_EN to add saturating commit/flush counters.    |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module rob_status_mw
  import rob_status_mw_pkg::*;
#(
  parameter int ADDR      = c_ADDR_WIDTH,
  parameter int ROB_DEPTH = c_ROB_DEPTH,
  parameter int DEC_W     = 2,
  parameter int WB_PORTS  = 3,
  parameter int COM_W     = 2,
  parameter int ROB       = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DEC_W-1:0]          dec_e_,
  input  logic [DEC_W*ADDR-1:0]     dec_pc,
  input  logic [DEC_W*c_REG_W-1:0]  dec_rd,
  input  logic [DEC_W-1:0]          dec_invalid,
  output logic [DEC_W*ROB-1:0]      dec_rob_id,
  output logic                      dec_ready,
  input  logic [WB_PORTS-1:0]       wb_e_,
  input  logic [WB_PORTS*ROB-1:0]   wb_rob_id,
  input  logic [WB_PORTS-1:0]       wb_exp_,
  input  logic [WB_PORTS*c_EXP_W-1:0] wb_exp_code,
  input  logic [WB_PORTS-1:0]       wb_pred_miss_,
  input  logic [WB_PORTS-1:0]       wb_jump_miss_,
  output logic [COM_W-1:0]          commit_e_,
  output logic [COM_W*ROB-1:0]      com_rob_id,
  output logic [COM_W*ADDR-1:0]     com_pc,
  output logic [COM_W*c_REG_W-1:0]  com_rd,
  output logic [COM_W-1:0]          com_exp_,
  output logic [COM_W*c_EXP_W-1:0]  com_exp_code,
  output logic                      flush_,
`ifdef ROB_PERF_EN
  output logic [31:0]               perf_commit_cnt,
  output logic [31:0]               perf_flush_cnt,
`endif
  output logic                      rob_busy
);

  logic [ROB-1:0]       r_head;
  logic [ROB-1:0]       r_tail;
  logic [ROB:0]         r_count;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_ready;
  logic [ADDR-1:0]      r_pc   [ROB_DEPTH];
  RegFile_t             r_rd   [ROB_DEPTH];
  RobStat_t             r_stat [ROB_DEPTH];

  logic [ROB-1:0]   w_win_idx [COM_W];
  logic [COM_W-1:0] w_win_done;
  logic [COM_W-1:0] w_win_fault;
  logic [ROB:0]     w_dec_n;
  logic [ROB:0]     w_ret_n;
  logic             w_accept;

  // Commit window; com_* read as zero on slots that are not retiring.
  generate
    for (genvar k = 0; k < COM_W; k++) begin : g_win
      assign w_win_idx[k]   = r_head + ROB'(k);
      assign w_win_done[k]  = r_valid[w_win_idx[k]] & r_ready[w_win_idx[k]];
      assign w_win_fault[k] = stat_fault(r_stat[w_win_idx[k]]);
      assign com_rob_id[k*ROB +: ROB]       = commit_e_[k] ? '0 : w_win_idx[k];
      assign com_pc[k*ADDR +: ADDR]         = commit_e_[k] ? '0 : r_pc[w_win_idx[k]];
      assign com_rd[k*c_REG_W +: c_REG_W]   = commit_e_[k] ? '0 : r_rd[w_win_idx[k]];
      assign com_exp_[k]                    = commit_e_[k] ? 1'b0 : r_stat[w_win_idx[k]].exp_;
      assign com_exp_code[k*c_EXP_W +: c_EXP_W] = commit_e_[k] ? '0 : r_stat[w_win_idx[k]].exp_code;
    end
    for (genvar k = 0; k < DEC_W; k++) begin : g_dec_id
      assign dec_rob_id[k*ROB +: ROB] = r_tail + ROB'(k);
    end
  endgenerate

  rob_commit_sel #(.COM_W(COM_W)) u_commit_sel (
    .i_win_done  (w_win_done),
    .i_win_fault (w_win_fault),
    .o_commit_e_ (commit_e_),
    .o_flush_    (flush_)
  );

  always_comb begin
    w_dec_n = '0;
    w_ret_n = '0;
    for (int k = 0; k < DEC_W; k++) w_dec_n = w_dec_n + {{ROB{1'b0}}, ~dec_e_[k]};
    for (int k = 0; k < COM_W; k++) w_ret_n = w_ret_n + {{ROB{1'b0}}, ~commit_e_[k]};
  end

  assign dec_ready = (r_count <= (ROB+1)'(ROB_DEPTH - DEC_W));
  assign rob_busy  = (r_count == (ROB+1)'(ROB_DEPTH));
  assign w_accept  = dec_ready & flush_;

  // Order matters: writeback, then retire clear, then allocate (targets never overlap legally).
  always_ff @(posedge clk) begin
    if (reset || !flush_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else begin
      for (int p = WB_PORTS-1; p >= 0; p--) begin
        if (!wb_e_[p] && r_valid[wb_rob_id[p*ROB +: ROB]]) begin
          r_ready[wb_rob_id[p*ROB +: ROB]] <= 1'b1;
          r_stat[wb_rob_id[p*ROB +: ROB]]  <= '{br_miss_: wb_pred_miss_[p], jump_miss_: wb_jump_miss_[p],
                                              exp_: wb_exp_[p], exp_code: wb_exp_code[p*c_EXP_W +: c_EXP_W]};
        end
      end
      for (int k = 0; k < COM_W; k++) begin
        if (!commit_e_[k]) begin
          r_valid[w_win_idx[k]] <= 1'b0;
          r_ready[w_win_idx[k]] <= 1'b0;
        end
      end
      if (w_accept) begin
        for (int k = 0; k < DEC_W; k++) begin
          if (!dec_e_[k]) begin
            r_valid[r_tail + ROB'(k)] <= 1'b1;
            r_ready[r_tail + ROB'(k)] <= dec_invalid[k];
            r_pc[r_tail + ROB'(k)]    <= dec_pc[k*ADDR +: ADDR];
            r_rd[r_tail + ROB'(k)]    <= dec_rd[k*c_REG_W +: c_REG_W];
            r_stat[r_tail + ROB'(k)]  <= c_STAT_CLEAN;
          end
        end
        r_tail <= r_tail + w_dec_n[ROB-1:0];
      end
      r_head  <= r_head + w_ret_n[ROB-1:0];
      r_count <= r_count + (w_accept ? w_dec_n : '0) - w_ret_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WB_PORTS; i++) begin
        for (int j = i + 1; j < WB_PORTS; j++) begin
          assert (wb_e_[i] || wb_e_[j] || (wb_rob_id[i*ROB +: ROB] != wb_rob_id[j*ROB +: ROB]));
        end
      end
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] r_perf_commit;
  logic [31:0] r_perf_flush;

  // Counters survive flushes; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_commit <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (r_perf_commit > (32'hFFFF_FFFF - 32'(w_ret_n))) r_perf_commit <= '1;
      else                                                r_perf_commit <= r_perf_commit + 32'(w_ret_n);
      if (!flush_ && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_commit_cnt = r_perf_commit;
  assign perf_flush_cnt  = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_status_mw.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_rob_status_mw                                               |
// | Description : Directed + random bench for rob_status_mw with queue model.    |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_rob_status_mw;
  import rob_status_mw_pkg::*;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dec_e_;
  logic [63:0] dec_pc;
  logic [9:0]  dec_rd;
  logic [1:0]  dec_invalid;
  logic [5:0]  dec_rob_id;
  logic        dec_ready;
  logic [2:0]  wb_e_;
  logic [8:0]  wb_rob_id;
  logic [2:0]  wb_exp_;
  logic [11:0] wb_exp_code;
  logic [2:0]  wb_pred_miss_;
  logic [2:0]  wb_jump_miss_;
  logic [1:0]  commit_e_;
  logic [5:0]  com_rob_id;
  logic [63:0] com_pc;
  logic [9:0]  com_rd;
  logic [1:0]  com_exp_;
  logic [7:0]  com_exp_code;
  logic        flush_;
  logic        rob_busy;
`ifdef ROB_PERF_EN
  logic [31:0] perf_commit_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  rob_status_mw #(.ADDR(32), .ROB_DEPTH(D), .DEC_W(2), .WB_PORTS(3), .COM_W(2)) dut (
    .clk(clk), .reset(reset), .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_rd(dec_rd),
    .dec_invalid(dec_invalid), .dec_rob_id(dec_rob_id), .dec_ready(dec_ready),
    .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_exp_(wb_exp_), .wb_exp_code(wb_exp_code),
    .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_), .commit_e_(commit_e_),
    .com_rob_id(com_rob_id), .com_pc(com_pc), .com_rd(com_rd), .com_exp_(com_exp_),
    .com_exp_code(com_exp_code), .flush_(flush_),
`ifdef ROB_PERF_EN
    .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .rob_busy(rob_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ROB contents as an in-order queue, oldest first.
  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          done;
    bit          exc;
    bit          brm;
    bit          jm;
    logic [3:0]  code;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;
  bit   chk_en = 1'b0;

  function automatic int model_commits(output bit fl);
    int n = 0;
    fl = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (fl || k >= q.size() || !q[k].done) break;
      n++;
      if (q[k].exc || q[k].brm || q[k].jm) fl = 1'b1;
    end
    return n;
  endfunction

  task automatic model_step();
    int   n;
    bit   fl;
    int   sz;
    ent_t e;
    if (reset) begin
      q.delete();
      m_tail = 0;
      return;
    end
    sz = q.size();
    n  = model_commits(fl);
    for (int p = 2; p >= 0; p--) begin
      if (!wb_e_[p]) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].id == int'(wb_rob_id[p*3 +: 3])) begin
            q[i].done = 1'b1;
            q[i].exc  = !wb_exp_[p];
            q[i].brm  = !wb_pred_miss_[p];
            q[i].jm   = !wb_jump_miss_[p];
            q[i].code = wb_exp_code[p*4 +: 4];
          end
        end
      end
    end
    repeat (n) void'(q.pop_front());
    if (fl) begin
      q.delete();
      m_tail = 0;
    end else if (D - sz >= 2) begin
      for (int k = 0; k < 2; k++) begin
        if (!dec_e_[k]) begin
          e.id = m_tail; e.pc = dec_pc[k*32 +: 32]; e.rd = dec_rd[k*5 +: 5];
          e.done = dec_invalid[k]; e.exc = 1'b0; e.brm = 1'b0; e.jm = 1'b0; e.code = 4'd0;
          q.push_back(e);
          m_tail = (m_tail + 1) % D;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    bit          fl;
    int          n;
    logic [1:0]  ce;
    logic [5:0]  ids;
    logic [63:0] pcs;
    logic [9:0]  rds;
    logic [1:0]  ex;
    logic [7:0]  cd;
    if (chk_en) begin
      n = model_commits(fl);
      ce = '1; ids = '0; pcs = '0; rds = '0; ex = '0; cd = '0;
      for (int k = 0; k < n; k++) begin
        ce[k] = 1'b0;
        ids[k*3 +: 3]  = 3'(q[k].id);
        pcs[k*32 +: 32] = q[k].pc;
        rds[k*5 +: 5]  = q[k].rd;
        ex[k]          = !q[k].exc;
        cd[k*4 +: 4]   = q[k].code;
      end
      check("commit_e_", commit_e_, ce);
      check("com_rob_id", com_rob_id, ids);
      check("com_pc", com_pc, pcs);
      check("com_rd", com_rd, rds);
      check("com_exp_", com_exp_, ex);
      check("com_exp_code", com_exp_code, cd);
      check("flush_", flush_, !fl);
      check("rob_busy", rob_busy, q.size() == D);
      check("dec_ready", dec_ready, (D - q.size()) >= 2);
      check("dec_rob_id", dec_rob_id, {3'(m_tail + 1), 3'(m_tail)});
    end
  end

  task automatic step(input logic [1:0] de, input logic [1:0] inv, input logic [2:0] we,
                      input logic [8:0] wid, input logic [2:0] wx, input logic [2:0] wpm,
                      input logic [2:0] wjm);
    dec_e_ = de; dec_invalid = inv; dec_pc = {$urandom, $urandom}; dec_rd = 10'($urandom);
    wb_e_ = we; wb_rob_id = wid; wb_exp_ = wx; wb_pred_miss_ = wpm; wb_jump_miss_ = wjm;
    wb_exp_code = 12'($urandom);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(2'b11, 2'b00, 3'b111, 9'd0, 3'b111, 3'b111, 3'b111);
  endtask

  task automatic disp2();
    step(2'b00, 2'b00, 3'b111, 9'd0, 3'b111, 3'b111, 3'b111);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    int a, b, c, n;
    logic [1:0] de;
    logic [2:0] wx, wpm, wjm;
    reset = 1'b1; dec_e_ = '1; dec_pc = '0; dec_rd = '0; dec_invalid = '0;
    wb_e_ = '1; wb_rob_id = '0; wb_exp_ = '1; wb_exp_code = '0; wb_pred_miss_ = '1; wb_jump_miss_ = '1;
    do_reset();
    chk_en = 1'b1;

    check("rst commit_e_", commit_e_, 2'b11);
    check("rst flush_", flush_, 1'b1);
    check("rst rob_busy", rob_busy, 1'b0);
    check("rst dec_ready", dec_ready, 1'b1);
    check("rst dec_rob_id", dec_rob_id, 6'b001_000);
    check("rst com_pc", com_pc, 64'd0);
    check("rst com_exp_", com_exp_, 2'b00);

    // Fill: ids 0,1 / 2,3 / 4,5 / 6,7, then a fifth group that must be dropped.
    for (int g = 0; g < 4; g++) begin
      check("fill dec_rob_id", dec_rob_id, {3'(2*g + 1), 3'(2*g)});
      disp2();
    end
    check("full rob_busy", rob_busy, 1'b1);
    check("full dec_ready", dec_ready, 1'b0);
    disp2();
    check("drop rob_busy", rob_busy, 1'b1);
    check("drop dec_rob_id", dec_rob_id, 6'b001_000);

    // Writeback id1 then id0: nothing retires until the head is ready.
    step(2'b11, 2'b00, 3'b110, {3'd0, 3'd0, 3'd1}, 3'b111, 3'b111, 3'b111);
    check("wb1 commit_e_", commit_e_, 2'b11);
    step(2'b11, 2'b00, 3'b110, {3'd0, 3'd0, 3'd0}, 3'b111, 3'b111, 3'b111);
    check("wb0 commit_e_", commit_e_, 2'b00);
    check("wb0 com_rob_id", com_rob_id, 6'b001_000);
    idle();
    check("post commit dec_ready", dec_ready, 1'b1);

    // Mispredict on head id2, clean id3: only slot0 retires and flushes.
    step(2'b11, 2'b00, 3'b100, {3'd0, 3'd3, 3'd2}, 3'b111, 3'b110, 3'b111);
    check("miss commit_e_", commit_e_, 2'b10);
    check("miss flush_", flush_, 1'b0);
    check("miss com_rob_id", com_rob_id, 6'b000_010);
    idle();
    check("post flush flush_", flush_, 1'b1);
    check("post flush rob_busy", rob_busy, 1'b0);
    check("post flush dec_rob_id", dec_rob_id, 6'b001_000);
`ifdef ROB_PERF_EN
    check("perf_commit_cnt", perf_commit_cnt, 32'd3);
    check("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

    // Full ROB: commit 2 while dispatching 2 -> dispatch dropped, then lands at wrapped tail.
    repeat (4) disp2();
    check("refill rob_busy", rob_busy, 1'b1);
    step(2'b11, 2'b00, 3'b100, {3'd0, 3'd1, 3'd0}, 3'b111, 3'b111, 3'b111);
    check("full commit_e_", commit_e_, 2'b00);
    disp2();
    check("wrap dec_rob_id", dec_rob_id, 6'b001_000);
    check("wrap dec_ready", dec_ready, 1'b1);
    disp2();
    check("wrap rob_busy", rob_busy, 1'b1);

    // Head id2 alone, then three ports to ids 3,4,5 -> retire 2 then 1.
    step(2'b11, 2'b00, 3'b110, {3'd0, 3'd0, 3'd2}, 3'b111, 3'b111, 3'b111);
    check("id2 commit_e_", commit_e_, 2'b10);
    step(2'b11, 2'b00, 3'b000, {3'd5, 3'd4, 3'd3}, 3'b111, 3'b111, 3'b111);
    check("3wb commit_e_ a", commit_e_, 2'b00);
    check("3wb com_rob_id a", com_rob_id, 6'b100_011);
    idle();
    check("3wb commit_e_ b", commit_e_, 2'b10);
    check("3wb com_rob_id b", com_rob_id, 6'b000_101);
    idle();
    check("3wb commit_e_ c", commit_e_, 2'b11);

    do_reset();
`ifdef ROB_PERF_EN
    check("perf_commit_cnt rst", perf_commit_cnt, 32'd0);
    check("perf_flush_cnt rst", perf_flush_cnt, 32'd0);
`endif

    // Random phase: distinct wb ids per cycle, rare faults and resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        n  = $urandom_range(0, 2);
        de = (n == 0) ? 2'b11 : (n == 1) ? 2'b10 : 2'b00;
        a  = $urandom_range(0, 7);
        b  = (a + 1 + $urandom_range(0, 6)) % 8;
        c  = (b + 1 + $urandom_range(0, 5)) % 8;
        if (c == a) c = (c + 1) % 8;
        if (c == b) c = (c + 1) % 8;
        if (c == a) c = (c + 1) % 8;
        for (int p = 0; p < 3; p++) begin
          wx[p]  = ($urandom_range(0, 39) != 0);
          wpm[p] = ($urandom_range(0, 39) != 0);
          wjm[p] = ($urandom_range(0, 39) != 0);
        end
        step(de, 2'($urandom) & 2'($urandom), 3'($urandom), {3'(c), 3'(b), 3'(a)}, wx, wpm, wjm);
      end
    end
    idle();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
